// File: rtl/display_pkg.sv
// Shared constants and helpers for the multiplexed 7-segment time display.
// Segment codes are active-low {dp,g,f,e,d,c,b,a}; dp is always off.
package display_pkg;

    localparam logic [7:0] SEG_0     = 8'hC0;
    localparam logic [7:0] SEG_1     = 8'hF9;
    localparam logic [7:0] SEG_2     = 8'hA4;
    localparam logic [7:0] SEG_3     = 8'hB0;
    localparam logic [7:0] SEG_4     = 8'h99;
    localparam logic [7:0] SEG_5     = 8'h92;
    localparam logic [7:0] SEG_6     = 8'h82;
    localparam logic [7:0] SEG_7     = 8'hF8;
    localparam logic [7:0] SEG_8     = 8'h80;
    localparam logic [7:0] SEG_9     = 8'h90;
    localparam logic [7:0] SEG_DASH  = 8'hBF;
    localparam logic [7:0] SEG_BLANK = 8'hFF;

    localparam int MAX_DISPLAY_VAL = 99;

    function automatic logic [7:0] bin2seg(input logic [3:0] d);
        logic [7:0] seg;
        case (d)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_BLANK;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/seg_scan_timer.sv
// Digit scan timer: holds each digit SCAN_DIV cycles and steps dig_idx
// through 0..DIGITS-1; frame_wrap marks the last cycle of a full frame.
module seg_scan_timer #(
    parameter int SCAN_DIV = 100000,
    parameter int DIGITS   = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    output logic [2:0] dig_idx,
    output logic       frame_wrap
);

    localparam int CW = $clog2(SCAN_DIV);

    logic [CW-1:0] scan_cnt;
    logic          cnt_wrap;

    assign cnt_wrap   = (scan_cnt == CW'(SCAN_DIV - 1));
    assign frame_wrap = cnt_wrap && (dig_idx == 3'(DIGITS - 1));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            scan_cnt <= '0;
            dig_idx  <= '0;
        end else if (cnt_wrap) begin
            scan_cnt <= '0;
            dig_idx  <= frame_wrap ? 3'd0 : dig_idx + 3'd1;
        end else begin
            scan_cnt <= scan_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/display_time_mux.sv
// Multiplexed two-digit-per-channel time display with frame snapshots.
// Optional per-channel blinking is compiled in with DISPLAY_BLINK_EN.
module display_time_mux
    import display_pkg::*;
#(
    parameter int NUM_CH       = 2,
    parameter int VAL_W        = 5,
    parameter int SCAN_DIV     = 100000,
    parameter int BLINK_FRAMES = 64
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NUM_CH*VAL_W-1:0] time_vals,
    input  logic                    dis,
    input  logic                    non,
    input  logic [NUM_CH-1:0]       blink_mask,
    output logic [7:0]              SIG_C,
    output logic [7:0]              POS
);

    localparam int DIGITS = 2 * NUM_CH;
    localparam int EW     = (VAL_W > 7) ? VAL_W : 7;

    logic [2:0]       dig_idx;
    logic             frame_wrap;
    logic [VAL_W-1:0] snap [NUM_CH];
    logic [1:0]       ch;
    logic [VAL_W-1:0] sel_val;
    logic [EW-1:0]    ext_val;
    logic [6:0]       sat_val;
    logic [3:0]       digit;
    logic [7:0]       pos_on;
    logic             blank_ch;

    seg_scan_timer #(
        .SCAN_DIV (SCAN_DIV),
        .DIGITS   (DIGITS)
    ) u_scan (
        .clk        (clk),
        .rst_n      (rst_n),
        .dig_idx    (dig_idx),
        .frame_wrap (frame_wrap)
    );

    // Latch all channels together so a frame never mixes old and new values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int k = 0; k < NUM_CH; k++) snap[k] <= '0;
        end else if (frame_wrap) begin
            for (int k = 0; k < NUM_CH; k++)
                snap[k] <= time_vals[k*VAL_W +: VAL_W];
        end
    end

    assign ch = dig_idx[2:1];

    always_comb begin
        sel_val = '0;
        for (int k = 0; k < NUM_CH; k++)
            if (ch == 2'(k)) sel_val = snap[k];
    end

    assign ext_val = EW'(sel_val);
    assign sat_val = (ext_val > EW'(MAX_DISPLAY_VAL)) ?
                     7'(MAX_DISPLAY_VAL) : ext_val[6:0];
    assign digit   = dig_idx[0] ? 4'(sat_val / 7'd10) : 4'(sat_val % 7'd10);
    assign pos_on  = ~(8'b1 << dig_idx);

`ifdef DISPLAY_BLINK_EN
    localparam int BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    logic [BW-1:0] blink_cnt;
    logic          blink_phase;
    logic          sel_mask;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            blink_cnt   <= '0;
            blink_phase <= 1'b0;
        end else if (frame_wrap) begin
            if (blink_cnt == BW'(BLINK_FRAMES - 1)) begin
                blink_cnt   <= '0;
                blink_phase <= ~blink_phase;
            end else begin
                blink_cnt <= blink_cnt + 1'b1;
            end
        end
    end

    always_comb begin
        sel_mask = 1'b0;
        for (int k = 0; k < NUM_CH; k++)
            if (ch == 2'(k)) sel_mask = blink_mask[k];
    end

    assign blank_ch = blink_phase & sel_mask;
`else
    logic unused_blink;

    assign unused_blink = ^blink_mask;
    assign blank_ch     = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            POS   <= 8'hFF;
            SIG_C <= SEG_BLANK;
        end else if (dis) begin
            POS   <= 8'hFF;
            SIG_C <= SEG_BLANK;
        end else if (blank_ch) begin
            POS   <= pos_on;
            SIG_C <= SEG_BLANK;
        end else if (non) begin
            POS   <= pos_on;
            SIG_C <= SEG_DASH;
        end else begin
            POS   <= pos_on;
            SIG_C <= bin2seg(digit);
        end
    end

endmodule

// File: tb/tb_display_time_mux.sv
// Directed bench for display_time_mux: scan order, snapshot, saturation,
// dash/blank modes and blinking (expectations follow DISPLAY_BLINK_EN).
module tb_display_time_mux;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [9:0] time_vals;
    logic       dis;
    logic       non;
    logic [1:0] blink_mask;
    logic [7:0] SIG_C;
    logic [7:0] POS;

    logic [6:0] sat_vals;
    logic [7:0] sat_sig;
    logic [7:0] sat_pos;

    int pass_cnt = 0;
    int total    = 0;

`ifdef DISPLAY_BLINK_EN
    localparam logic [7:0] BL_ONES6 = 8'hFF;
    localparam logic [7:0] BL_TENS1 = 8'hFF;
`else
    localparam logic [7:0] BL_ONES6 = 8'h82;
    localparam logic [7:0] BL_TENS1 = 8'hF9;
`endif

    always #5 clk = ~clk;

    display_time_mux #(
        .NUM_CH       (2),
        .VAL_W        (5),
        .SCAN_DIV     (4),
        .BLINK_FRAMES (2)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .time_vals  (time_vals),
        .dis        (dis),
        .non        (non),
        .blink_mask (blink_mask),
        .SIG_C      (SIG_C),
        .POS        (POS)
    );

    display_time_mux #(
        .NUM_CH       (1),
        .VAL_W        (7),
        .SCAN_DIV     (4),
        .BLINK_FRAMES (2)
    ) dut_sat (
        .clk        (clk),
        .rst_n      (rst_n),
        .time_vals  (sat_vals),
        .dis        (1'b0),
        .non        (1'b0),
        .blink_mask (1'b0),
        .SIG_C      (sat_sig),
        .POS        (sat_pos)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] p, input logic [7:0] s,
                       input logic [7:0] ep, input logic [7:0] es);
        total++;
        assert ({p, s} === {ep, es}) begin
            pass_cnt++;
        end else begin
            $error("FAIL %s: POS/SIG_C=%h/%h expected %h/%h", tag, p, s, ep, es);
        end
    endtask

    // Checks first and last cycle of a digit slot, ends on the next slot.
    task automatic chk_digit(input string tag, input logic [7:0] ep,
                             input logic [7:0] es);
        chk(tag, POS, SIG_C, ep, es);
        repeat (3) tick();
        chk({tag, "_hold"}, POS, SIG_C, ep, es);
        tick();
    endtask

    task automatic chk_frame(input string tag, input logic [7:0] s0,
                             input logic [7:0] s1, input logic [7:0] s2,
                             input logic [7:0] s3);
        chk_digit({tag, "_d0"}, 8'hFE, s0);
        chk_digit({tag, "_d1"}, 8'hFD, s1);
        chk_digit({tag, "_d2"}, 8'hFB, s2);
        chk_digit({tag, "_d3"}, 8'hF7, s3);
    endtask

    initial begin
        rst_n      = 1'b0;
        time_vals  = '0;
        dis        = 1'b0;
        non        = 1'b0;
        blink_mask = 2'b00;
        sat_vals   = 7'd120;

        repeat (3) tick();
        chk("reset", POS, SIG_C, 8'hFF, 8'hFF);
        chk("reset_sat", sat_pos, sat_sig, 8'hFF, 8'hFF);

        rst_n     = 1'b1;
        time_vals = {5'd16, 5'd13};
        tick();

        // Frame 1: no snapshot yet, all channels read 00.
        chk_frame("pre_snap", 8'hC0, 8'hC0, 8'hC0, 8'hC0);
        chk_frame("vals", 8'hB0, 8'hF9, 8'h82, 8'hF9);

        // Change ch0 to 7 right after digit 0 of frame 3.
        chk_digit("snap_f3_d0", 8'hFE, 8'hB0);
        time_vals = {5'd16, 5'd7};
        chk_digit("snap_f3_d1", 8'hFD, 8'hF9);
        chk_digit("snap_f3_d2", 8'hFB, 8'h82);
        chk_digit("snap_f3_d3", 8'hF7, 8'hF9);
        chk_frame("snap_new", 8'hF8, 8'hC0, 8'h82, 8'hF9);

        // Frame 5 starts here; non takes effect on the next register update.
        non = 1'b1;
        tick();
        chk("non_d0", POS, SIG_C, 8'hFE, 8'hBF);
        repeat (4) tick();
        chk("non_d1", POS, SIG_C, 8'hFD, 8'hBF);
        repeat (4) tick();
        chk("non_d2", POS, SIG_C, 8'hFB, 8'hBF);
        repeat (4) tick();
        chk("non_d3", POS, SIG_C, 8'hF7, 8'hBF);
        repeat (4) tick();

        dis = 1'b1;
        tick();
        chk("dis_non_a", POS, SIG_C, 8'hFF, 8'hFF);
        tick();
        chk("dis_non_b", POS, SIG_C, 8'hFF, 8'hFF);
        dis = 1'b0;
        tick();
        chk("dis_release", POS, SIG_C, 8'hFD, 8'hBF);
        non = 1'b0;
        tick();
        chk("non_release", POS, SIG_C, 8'hFD, 8'hC0);

        // Frames 7 and 8 fall in blink phase 1, frame 9 in phase 0.
        blink_mask = 2'b10;
        repeat (11) tick();
        chk_frame("blink_f7", 8'hF8, 8'hC0, BL_ONES6, BL_TENS1);
        chk_frame("blink_f8", 8'hF8, 8'hC0, BL_ONES6, BL_TENS1);
        chk_frame("blink_f9", 8'hF8, 8'hC0, 8'h82, 8'hF9);

        chk("sat_d0", sat_pos, sat_sig, 8'hFE, 8'h90);
        repeat (4) tick();
        chk("sat_d1", sat_pos, sat_sig, 8'hFD, 8'h90);

        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule
